// File: rtl/fetcher.sv
// Instruction fetcher: issues one word read at a time, queues {pc, inst} pairs and hands the head to the decoder.
// Optional FETCHER_JAL_PREDICT_EN: follow JAL targets when a pushed word is a JAL instead of advancing by 4.
module fetcher #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        out_mem_req_enable,
  output logic [31:0] out_mem_addr,
  input  logic        in_mem_valid,
  input  logic [31:0] in_mem_inst,
  input  logic        in_stall,
  output logic        out_fetch_enable,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        in_rob_flush,
  input  logic [31:0] in_rob_target_pc,
  output logic [1:0]  out_dbg_state
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    DISCARD  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem_q   [QUEUE_DEPTH];
  logic [31:0]   inst_mem_q [QUEUE_DEPTH];

  logic        flush;
  logic        req;
  logic        push;
  logic        pop;
  logic        not_full;
  logic [31:0] next_pc;

  assign flush         = rdy & in_rob_flush;
  assign not_full      = count_q < CW'(QUEUE_DEPTH);
  assign out_dbg_state = state_q;

`ifdef FETCHER_JAL_PREDICT_EN
  always_comb begin
    next_pc = fetch_pc_q + 32'd4;
    if (in_mem_inst[6:0] == 7'b1101111) begin
      next_pc = fetch_pc_q + {{11{in_mem_inst[31]}}, in_mem_inst[31], in_mem_inst[19:12],
                              in_mem_inst[20], in_mem_inst[30:21], 1'b0};
    end
  end
`else
  assign next_pc = fetch_pc_q + 32'd4;
`endif

  // Handshakes: a request is a one-cycle pulse, the word comes back as a one-cycle in_mem_valid;
  // the decoder takes the head whenever out_fetch_enable is high (no backpressure beyond in_stall).
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req        = 1'b0;
    push       = 1'b0;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            fetch_pc_d = in_rob_target_pc;
          end else if (not_full) begin
            req     = 1'b1;
            state_d = WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          if (flush) begin
            fetch_pc_d = in_rob_target_pc;
            state_d    = in_mem_valid ? IDLE : DISCARD;
          end else if (in_mem_valid) begin
            push       = 1'b1;
            fetch_pc_d = next_pc;
            state_d    = IDLE;
          end
        end
        DISCARD: begin
          if (flush) fetch_pc_d = in_rob_target_pc;
          if (in_mem_valid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Reset is combined in so the request pulse drops the instant rst rises.
  assign out_mem_req_enable = req & ~rst;
  assign out_mem_addr       = out_mem_req_enable ? fetch_pc_q : 32'h0;
  assign pop                = (count_q != '0) & ~in_stall & rdy & ~in_rob_flush;
  assign out_fetch_enable   = pop;
  assign out_inst           = inst_mem_q[head_q];
  assign out_pc             = pc_mem_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + PW'(1);
      if (push) tail_d = tail_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[tail_q]   <= fetch_pc_q;
      inst_mem_q[tail_q] <= in_mem_inst;
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: request addresses and decoder hand-offs are checked against expected queues.
module tb_fetcher;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        out_mem_req_enable;
  logic [31:0] out_mem_addr;
  logic        in_mem_valid;
  logic [31:0] in_mem_inst;
  logic        in_stall;
  logic        out_fetch_enable;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        in_rob_flush;
  logic [31:0] in_rob_target_pc;
  logic [1:0]  out_dbg_state;

  fetcher #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .out_mem_req_enable(out_mem_req_enable), .out_mem_addr(out_mem_addr),
    .in_mem_valid(in_mem_valid), .in_mem_inst(in_mem_inst), .in_stall(in_stall),
    .out_fetch_enable(out_fetch_enable), .out_inst(out_inst), .out_pc(out_pc),
    .in_rob_flush(in_rob_flush), .in_rob_target_pc(in_rob_target_pc),
    .out_dbg_state(out_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_pop_q[$];
  int checks;
  int failures;
  int cyc;
  int first_req_cyc;
  int first_pop_cyc;
  logic chk_req, chk_pop, mem_en;
  logic mem_pending_n;
  logic [31:0] pend_addr;

  function automatic logic [31:0] inst_for(input logic [31:0] addr);
    return {addr[11:0], 5'd1, 3'b000, 5'd1, 7'b0010011};  // ADDI x1, x1, addr
  endfunction

  // One clock: monitor outputs at negedge, then drive the memory model after the rising edge.
  task automatic tick();
    logic [31:0] e;
    logic [63:0] ep;
    @(negedge clk);
    mem_pending_n = 1'b0;
    if (!rst && out_mem_req_enable) begin
      mem_pending_n = 1'b1;
      pend_addr     = out_mem_addr;
      if (first_req_cyc < 0) first_req_cyc = cyc;
      if (chk_req) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++;
          $display("FAIL req_unexpected: got addr=%h, required no request (cycle %0d)", out_mem_addr, cyc);
        end else begin
          e = exp_addr_q.pop_front();
          if (out_mem_addr !== e) begin
            failures++;
            $display("FAIL req_addr: got %h, required %h (cycle %0d)", out_mem_addr, e, cyc);
          end
        end
      end
    end
    if (!rst && out_fetch_enable) begin
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      if (chk_pop) begin
        checks++;
        if (exp_pop_q.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected: got pc=%h inst=%h, required no fetch (cycle %0d)", out_pc, out_inst, cyc);
        end else begin
          ep = exp_pop_q.pop_front();
          if ({out_pc, out_inst} !== ep) begin
            failures++;
            $display("FAIL pop_entry: got pc=%h inst=%h, required pc=%h inst=%h", out_pc, out_inst, ep[63:32], ep[31:0]);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mem_en) begin
      in_mem_valid = mem_pending_n;
      in_mem_inst  = mem_pending_n ? inst_for(pend_addr) : 32'h0;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    rdy = 1'b1; in_stall = 1'b0; in_mem_valid = 1'b0; in_mem_inst = 32'h0;
    in_rob_flush = 1'b0; in_rob_target_pc = 32'h0;
    chk_req = 1'b0; chk_pop = 1'b0; mem_en = 1'b0; mem_pending_n = 1'b0; pend_addr = 32'h0;
    exp_addr_q.delete();
    exp_pop_q.delete();
    first_req_cyc = -1;
    first_pop_cyc = -1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdy = 1'b1; in_stall = 1'b0; in_mem_valid = 1'b0; in_mem_inst = 32'h0;
    in_rob_flush = 1'b0; in_rob_target_pc = 32'h0;
    #3;
    checks++; if (out_mem_req_enable !== 1'b0) begin failures++; $display("FAIL rst_req: got %b, required 0", out_mem_req_enable); end
    checks++; if (out_mem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h, required 0", out_mem_addr); end
    checks++; if (out_fetch_enable !== 1'b0) begin failures++; $display("FAIL rst_fetch: got %b, required 0", out_fetch_enable); end
    checks++; if (out_inst !== 32'h0) begin failures++; $display("FAIL rst_inst: got %h, required 0", out_inst); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h, required 0", out_pc); end
    apply_reset();
    #1;
    checks++; if (out_dbg_state !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d, required 0", out_dbg_state); end
    checks++;
    if (out_mem_req_enable !== 1'b1 || out_mem_addr !== 32'h0) begin
      failures++; $display("FAIL first_req: got en=%b addr=%h, required en=1 addr=0", out_mem_req_enable, out_mem_addr);
    end
  endtask

  task automatic test_basic();
    int n;
    apply_reset();
    mem_en = 1'b1; chk_req = 1'b1; chk_pop = 1'b1;
    for (int i = 0; i < 5; i++) exp_addr_q.push_back(32'(i * 4));
    for (int i = 0; i < 4; i++) exp_pop_q.push_back({32'(i * 4), inst_for(32'(i * 4))});
    n = 0;
    while (exp_pop_q.size() != 0 && n < 40) begin tick(); n++; end
    checks++; if (exp_pop_q.size() != 0) begin failures++; $display("FAIL basic_timeout: got %0d pops left, required 0", exp_pop_q.size()); end
    checks++; if (exp_addr_q.size() != 0) begin failures++; $display("FAIL basic_reqs: got %0d reqs left, required 0", exp_addr_q.size()); end
    checks++;
    if (first_pop_cyc - first_req_cyc != 2) begin
      failures++; $display("FAIL latency: got %0d cycles, required 2", first_pop_cyc - first_req_cyc);
    end
    chk_req = 1'b0; chk_pop = 1'b0; mem_en = 1'b0;
  endtask

  task automatic test_stall();
    int n;
    apply_reset();
    in_stall = 1'b1; mem_en = 1'b1; chk_req = 1'b1; chk_pop = 1'b1;
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'(i * 4));
    repeat (20) tick();
    checks++; if (exp_addr_q.size() != 0) begin failures++; $display("FAIL stall_fill: got %0d reqs missing, required 0", exp_addr_q.size()); end
    for (int i = 0; i < 4; i++) exp_pop_q.push_back({32'(i * 4), inst_for(32'(i * 4))});
    exp_addr_q.push_back(32'd16);
    exp_addr_q.push_back(32'd20);
    in_stall = 1'b0;
    n = 0;
    while (exp_pop_q.size() != 0 && n < 30) begin tick(); n++; end
    checks++; if (exp_pop_q.size() != 0) begin failures++; $display("FAIL stall_drain: got %0d pops left, required 0", exp_pop_q.size()); end
    checks++; if (exp_addr_q.size() != 0) begin failures++; $display("FAIL stall_resume: got %0d reqs left, required 0", exp_addr_q.size()); end
    chk_req = 1'b0; chk_pop = 1'b0; mem_en = 1'b0;
  endtask

  task automatic test_flush_wait();
    apply_reset();
    in_stall = 1'b1; chk_req = 1'b1; chk_pop = 1'b1;
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    tick();
    in_mem_valid = 1'b1; in_mem_inst = inst_for(32'h0);
    tick();
    in_mem_valid = 1'b0;
    tick();
    in_rob_flush = 1'b1; in_rob_target_pc = 32'h100; in_stall = 1'b0;
    #1;
    checks++; if (out_fetch_enable !== 1'b0) begin failures++; $display("FAIL flush_blocks_pop: got %b, required 0", out_fetch_enable); end
    tick();
    in_rob_flush = 1'b0; in_mem_valid = 1'b1; in_mem_inst = inst_for(32'h4);
    #1;
    checks++; if (out_fetch_enable !== 1'b0) begin failures++; $display("FAIL flush_queue_empty: got %b, required 0", out_fetch_enable); end
    checks++; if (out_dbg_state !== 2'd2) begin failures++; $display("FAIL flush_discard_state: got %0d, required 2", out_dbg_state); end
    checks++; if (out_mem_req_enable !== 1'b0) begin failures++; $display("FAIL discard_no_req: got %b, required 0", out_mem_req_enable); end
    tick();
    in_mem_valid = 1'b0;
    exp_addr_q.push_back(32'h100);
    #1;
    checks++;
    if (out_mem_req_enable !== 1'b1 || out_mem_addr !== 32'h100) begin
      failures++; $display("FAIL flush_target_req: got en=%b addr=%h, required en=1 addr=00000100", out_mem_req_enable, out_mem_addr);
    end
    tick();
    chk_req = 1'b0;
    in_mem_valid = 1'b1; in_mem_inst = inst_for(32'h100);
    exp_pop_q.push_back({32'h100, inst_for(32'h100)});
    tick();
    in_mem_valid = 1'b0;
    tick();
    checks++; if (exp_pop_q.size() != 0) begin failures++; $display("FAIL flush_after_pop: got %0d pops left, required 0", exp_pop_q.size()); end
    chk_pop = 1'b0;
  endtask

  task automatic test_flush_valid();
    apply_reset();
    in_stall = 1'b1; chk_req = 1'b1; chk_pop = 1'b1;
    exp_addr_q.push_back(32'h0);
    tick();
    in_mem_valid = 1'b1; in_mem_inst = inst_for(32'h0);
    in_rob_flush = 1'b1; in_rob_target_pc = 32'h200; in_stall = 1'b0;
    tick();
    in_mem_valid = 1'b0; in_rob_flush = 1'b0;
    exp_addr_q.push_back(32'h200);
    #1;
    checks++; if (out_fetch_enable !== 1'b0) begin failures++; $display("FAIL flush_valid_dropped: got %b, required 0", out_fetch_enable); end
    checks++; if (out_dbg_state !== 2'd0) begin failures++; $display("FAIL flush_valid_state: got %0d, required 0", out_dbg_state); end
    tick();
    checks++; if (exp_addr_q.size() != 0) begin failures++; $display("FAIL flush_valid_req: got %0d reqs left, required 0", exp_addr_q.size()); end
    chk_req = 1'b0; chk_pop = 1'b0;
  endtask

  task automatic test_jal();
    apply_reset();
    in_stall = 1'b1; chk_req = 1'b1;
    exp_addr_q.push_back(32'h0);
    tick();
    in_mem_valid = 1'b1; in_mem_inst = 32'h0080006F;
    tick();
    in_mem_valid = 1'b0;
`ifdef FETCHER_JAL_PREDICT_EN
    exp_addr_q.push_back(32'h8);
`else
    exp_addr_q.push_back(32'h4);
`endif
    tick();
    checks++; if (exp_addr_q.size() != 0) begin failures++; $display("FAIL jal_next: got %0d reqs left, required 0", exp_addr_q.size()); end
    chk_req = 1'b0;
  endtask

  task automatic test_rdy_low();
    apply_reset();
    in_stall = 1'b1; chk_req = 1'b1; chk_pop = 1'b1;
    rdy = 1'b0;
    repeat (4) tick();
    #1;
    checks++; if (out_mem_req_enable !== 1'b0) begin failures++; $display("FAIL rdy_no_req: got %b, required 0", out_mem_req_enable); end
    rdy = 1'b1;
    exp_addr_q.push_back(32'h0);
    tick();
    rdy = 1'b0; in_mem_valid = 1'b1; in_mem_inst = 32'hCAFE0013;
    tick();
    tick();
    #1;
    checks++; if (out_dbg_state !== 2'd1) begin failures++; $display("FAIL rdy_hold_state: got %0d, required 1", out_dbg_state); end
    rdy = 1'b1; in_stall = 1'b0; in_mem_inst = inst_for(32'h0);
    exp_pop_q.push_back({32'h0, inst_for(32'h0)});
    tick();
    in_mem_valid = 1'b0; chk_req = 1'b0;
    tick();
    checks++; if (exp_pop_q.size() != 0) begin failures++; $display("FAIL rdy_resume_pop: got %0d pops left, required 0", exp_pop_q.size()); end
    chk_pop = 1'b0;
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    in_stall = 1'b1; mem_en = 1'b1;
    repeat (7) tick();
    mem_en = 1'b0; in_mem_valid = 1'b0; in_stall = 1'b0;
    #1;
    checks++; if (out_dbg_state !== 2'd1) begin failures++; $display("FAIL mid_pre_state: got %0d, required 1", out_dbg_state); end
    checks++; if (out_pc !== 32'h0 || out_fetch_enable !== 1'b1) begin failures++; $display("FAIL mid_pre_head: got pc=%h en=%b, required pc=0 en=1", out_pc, out_fetch_enable); end
    rst = 1'b1;
    #1;
    checks++;
    if (out_mem_req_enable !== 1'b0 || out_mem_addr !== 32'h0 || out_fetch_enable !== 1'b0 ||
        out_inst !== 32'h0 || out_pc !== 32'h0) begin
      failures++;
      $display("FAIL mid_rst_outputs: got req=%b addr=%h fe=%b inst=%h pc=%h, required all 0",
               out_mem_req_enable, out_mem_addr, out_fetch_enable, out_inst, out_pc);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (out_mem_req_enable !== 1'b1 || out_mem_addr !== 32'h0 || out_fetch_enable !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_release: got req=%b addr=%h fe=%b, required req=1 addr=0 fe=0",
               out_mem_req_enable, out_mem_addr, out_fetch_enable);
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    test_reset();
    test_basic();
    test_stall();
    test_flush_wait();
    test_flush_valid();
    test_jal();
    test_rdy_low();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
